uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rr_picker.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit arbiter slice.
//   arb_state_t     - arbiter FSM state encoding (IDLE, SEND, FRAME)
//   DATA_W          - width of one UART data byte
//   FRAME_TICKS_DEF - default baud ticks per frame: start + 8 data + parity
//                     + stop (11), plus 1 so the stop bit runs its full length
package uart_pkg;

    localparam int DATA_W          = 8;
    localparam int FRAME_TICKS_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_FRAME = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin selector.
// Scans the valid vector starting at ptr and wrapping around. The first set
// bit it finds wins.
// Ports:
//   valid [NUM_REQ]  - request flags
//   ptr   [IDX_W]    - index that gets first priority (always < NUM_REQ)
//   grant [NUM_REQ]  - one-hot winner; all zero when nothing is valid
//   idx   [IDX_W]    - index of the winner; 0 when nothing is valid
//   any              - at least one request is valid
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: lets NUM_REQ requesters share one uart_tx by round-robin.
// In IDLE it grants one pending requester and latches that requester's byte
// and parity select. SEND then pulses the start strobe for one cycle. FRAME
// counts FRAME_TICKS baud ticks and then returns to IDLE.
// Optional feature macro: UART_TX_ARB_STATS_EN adds the frames_sent counter.
// Ports:
//   clk, reset (async, active-high)
//   req_valid [NUM_REQ]    - per-requester byte pending (level)
//   req_data  [NUM_REQ*8]  - requester i occupies bits [8i+7:8i]
//   req_psel  [NUM_REQ]    - per-requester parity select
//   req_ready [NUM_REQ]    - one-hot acceptance pulse
//   bclk_tx                - baud tick shared with uart_tx
//   send, d_in_tx, p_sel   - interface to uart_tx
//   busy                   - FSM is not in IDLE
//   grant_id               - index of the last accepted requester
//   frames_sent [16]       - completed frames (UART_TX_ARB_STATS_EN only)
//   fsm_state              - current FSM state, for debug and checkers
//
// Handshake: a requester holds req_valid with stable req_data/req_psel until
// it sees req_ready. req_ready is high for exactly one cycle, and the transfer
// happens in that cycle. The requester may drop or change req_valid and its
// data in the following cycle. A requester that drops req_valid before it is
// granted is skipped, and nothing else changes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_TICKS = FRAME_TICKS_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_psel,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        bclk_tx,
    output logic                        send,
    output logic [DATA_W-1:0]           d_in_tx,
    output logic                        p_sel,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
`ifdef UART_TX_ARB_STATS_EN
    output logic [15:0]                 frames_sent,
`endif
    output arb_state_t                  fsm_state
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int TICK_W = $clog2(FRAME_TICKS) + 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(FRAME_TICKS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_t        state, state_next;
    logic [TICK_W-1:0] tick_cnt, tick_next;
    logic [IDX_W-1:0]  rr_ptr;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               grant_now;
    logic               frame_done;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A grant happens only in IDLE. It is also blocked while reset is held,
    // because the picker is combinational and would otherwise pulse req_ready
    // during reset.
    assign grant_now  = (state == ST_IDLE) && pick_any && !reset;
    assign frame_done = (state == ST_FRAME) && bclk_tx && (tick_cnt == LAST_TICK);

    assign req_ready = grant_now ? pick_grant : '0;
    assign send      = (state == ST_SEND);
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        case (state)
            ST_IDLE: begin
                tick_next = '0;
                if (pick_any) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                // A tick that lands on the start strobe is not counted.
                tick_next  = '0;
                state_next = ST_FRAME;
            end
            ST_FRAME: begin
                if (bclk_tx) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_next  = '0;
                        state_next = ST_IDLE;
                    end else begin
                        tick_next = tick_cnt + 1'b1;
                    end
                end
            end
            default: begin
                tick_next  = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
        end
    end

    // The latched outputs stay stable from one grant to the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            d_in_tx  <= '0;
            p_sel    <= 1'b0;
            grant_id <= '0;
        end else if (grant_now) begin
            d_in_tx  <= req_data[pick_idx*DATA_W +: DATA_W];
            p_sel    <= req_psel[pick_idx];
            grant_id <= pick_idx;
            rr_ptr   <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        end
    end

`ifdef UART_TX_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frames_sent <= '0;
        end else if (frame_done) begin
            frames_sent <= frames_sent + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_psel;
    logic [3:0]  req_ready;
    logic        bclk_tx;
    logic        send;
    logic [7:0]  d_in_tx;
    logic        p_sel;
    logic        busy;
    logic [1:0]  grant_id;
`ifdef UART_TX_ARB_STATS_EN
    logic [15:0] frames_sent;
`endif
    arb_state_t  fsm_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_id;

    uart_tx_arbiter #(.NUM_REQ(4), .FRAME_TICKS(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_psel  (req_psel),
        .req_ready (req_ready),
        .bclk_tx   (bclk_tx),
        .send      (send),
        .d_in_tx   (d_in_tx),
        .p_sel     (p_sel),
        .busy      (busy),
        .grant_id  (grant_id),
`ifdef UART_TX_ARB_STATS_EN
        .frames_sent (frames_sent),
`endif
        .fsm_state (fsm_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int gap);
        repeat (gap - 1) step();
        bclk_tx = 1'b1;
        step();
        bclk_tx = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_data  = 32'h443322A5;
        req_psel  = 4'b0000;
        bclk_tx   = 1'b0;

        // reset state
        step();
        step();
        chk("rst_send",  {31'd0, send},     32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_data",  {24'd0, d_in_tx},  32'd0);
        chk("rst_psel",  {31'd0, p_sel},    32'd0);
        chk("rst_gid",   {30'd0, grant_id}, 32'd0);
        chk("rst_busy",  {31'd0, busy},     32'd0);
        reset = 1'b0;
        step();

        // single request, slow baud
        req_valid = 4'b0001;
        #1;
        chk("a_ready", {28'd0, req_ready}, 32'h1);
        step();
        req_valid = 4'b0000;
        chk("a_send",  {31'd0, send},    32'd1);
        chk("a_state", {30'd0, fsm_state}, {30'd0, ST_SEND});
        chk("a_data",  {24'd0, d_in_tx}, 32'hA5);
        chk("a_gid",   {30'd0, grant_id}, 32'd0);
        step();
        chk("a_send_off", {31'd0, send}, 32'd0);
        repeat (11) tick(16);
        chk("a_busy_11", {31'd0, busy}, 32'd1);
        chk("a_data_held", {24'd0, d_in_tx}, 32'hA5);
        tick(16);
        chk("a_busy_12", {31'd0, busy}, 32'd0);

        // all four requesters, fresh rotation
        reset = 1'b1;
        req_data  = 32'h44332211;
        req_psel  = 4'b1010;
        req_valid = 4'b1111;
        step();
        chk("b_rst_ready", {28'd0, req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
        for (int k = 0; k < 4; k++) begin
            exp_id = exp_q.pop_front();
            chk("b_ready", {28'd0, req_ready}, 32'd1 << exp_id);
            step();
            chk("b_gid",  {30'd0, grant_id}, exp_id);
            chk("b_data", {24'd0, d_in_tx},  32'h11 * (exp_id + 1));
            chk("b_psel", {31'd0, p_sel},    {31'd0, exp_id[0]});
            chk("b_send", {31'd0, send},     32'd1);
            step();
            chk("b_ready_frame", {28'd0, req_ready}, 32'd0);
            repeat (12) tick(2);
        end

        // fairness plus a tick coincident with send
        req_psel  = 4'b0001;
        req_valid = 4'b0100;
        #1;
        chk("c_ready2", {28'd0, req_ready}, 32'h4);
        step();
        req_valid = 4'b0000;
        bclk_tx   = 1'b1;
        chk("c_send", {31'd0, send}, 32'd1);
        step();
        bclk_tx   = 1'b0;
        req_valid = 4'b0101;
        #1;
        chk("c_ready_busy", {28'd0, req_ready}, 32'd0);
        repeat (11) tick(2);
        chk("c_busy_11", {31'd0, busy}, 32'd1);
        tick(2);
        chk("c_busy_12", {31'd0, busy}, 32'd0);
        chk("c_ready0",  {28'd0, req_ready}, 32'h1);
        step();
        req_valid = 4'b0000;
        chk("c_gid", {30'd0, grant_id}, 32'd0);
        chk("c_psel", {31'd0, p_sel}, 32'd1);
        step();

        // reset on the 5th tick of a frame
        repeat (4) tick(2);
        step();
        bclk_tx   = 1'b1;
        reset     = 1'b1;
        req_valid = 4'b1000;
        #1;
        chk("d_busy",  {31'd0, busy},      32'd0);
        chk("d_send",  {31'd0, send},      32'd0);
        chk("d_data",  {24'd0, d_in_tx},   32'd0);
        chk("d_gid",   {30'd0, grant_id},  32'd0);
        chk("d_psel",  {31'd0, p_sel},     32'd0);
        chk("d_ready", {28'd0, req_ready}, 32'd0);
        step();
        bclk_tx   = 1'b0;
        req_valid = 4'b0000;
        reset     = 1'b0;
        step();
        chk("d_no_resend", {31'd0, send}, 32'd0);
        chk("d_idle",      {31'd0, busy}, 32'd0);
        req_valid = 4'b1000;
        #1;
        chk("d_ready3", {28'd0, req_ready}, 32'h8);
        step();
        req_valid = 4'b0000;
        chk("d_gid3",  {30'd0, grant_id}, 32'd3);
        chk("d_data3", {24'd0, d_in_tx},  32'h44);
        chk("d_send3", {31'd0, send},     32'd1);
        step();
        repeat (12) tick(2);
        req_valid = 4'b1001;
        #1;
        chk("d_ptr0", {28'd0, req_ready}, 32'h1);
`ifdef UART_TX_ARB_STATS_EN
        chk("s_frames", {16'd0, frames_sent}, 32'd1);
`endif
        req_valid = 4'b0000;
        step();
        step();

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
